// File: rtl/control_pkg.sv
// Shared encodings for the instruction decoder: opcodes, R-type functs, ALU ops and
// the packed control-bit bundle.
package control_pkg;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAddiu = 6'h09;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnSll  = 6'h00;
    localparam logic [5:0] FnAdd  = 6'h20;
    localparam logic [5:0] FnAddu = 6'h21;
    localparam logic [5:0] FnSub  = 6'h22;
    localparam logic [5:0] FnSubu = 6'h23;
    localparam logic [5:0] FnAnd  = 6'h24;
    localparam logic [5:0] FnOr   = 6'h25;
    localparam logic [5:0] FnSlt  = 6'h2A;
    localparam logic [5:0] FnSltu = 6'h2B;

    localparam logic [2:0] AluAdd  = 3'b000;
    localparam logic [2:0] AluSub  = 3'b001;
    localparam logic [2:0] AluAnd  = 3'b010;
    localparam logic [2:0] AluOr   = 3'b011;
    localparam logic [2:0] AluSlt  = 3'b100;
    localparam logic [2:0] AluSltu = 3'b101;
    localparam logic [2:0] AluSll  = 3'b110;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       reg_dst;
        logic       alu_src;
        logic       mem_wr;
        logic       mem_to_reg;
        logic       reg_wr;
        logic       ext_op;
    } ctrl_t;

    // Safe decode for anything unsupported: no writes, ADD, everything else low.
    localparam ctrl_t CtrlNop = '0;

endpackage

// File: rtl/control_if.sv
// Instruction in / decoded controls and raw fields out.
interface control_if;

    logic [31:0] inst;
    logic [2:0]  alu_op;
    logic        reg_dst;
    logic        alu_src;
    logic        mem_wr;
    logic        mem_to_reg;
    logic        reg_wr;
    logic        ext_op;
    logic [5:0]  func;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;

    modport master (
        output inst,
        input  alu_op, reg_dst, alu_src, mem_wr, mem_to_reg, reg_wr, ext_op,
        input  func, shamt, rs, rt, rd, imm
    );

    modport slave (
        input  inst,
        output alu_op, reg_dst, alu_src, mem_wr, mem_to_reg, reg_wr, ext_op,
        output func, shamt, rs, rt, rd, imm
    );

endinterface

// File: rtl/control_decode.sv
// Combinational opcode/funct to control-bit decode.
module control_decode
    import control_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = CtrlNop;
        case (opcode)
            OpRtype: begin
                ctrl.reg_dst = 1'b1;
                ctrl.reg_wr  = 1'b1;
                case (funct)
                    FnAdd, FnAddu: ctrl.alu_op = AluAdd;
                    FnSub, FnSubu: ctrl.alu_op = AluSub;
                    FnAnd:         ctrl.alu_op = AluAnd;
                    FnOr:          ctrl.alu_op = AluOr;
                    FnSlt:         ctrl.alu_op = AluSlt;
                    FnSltu:        ctrl.alu_op = AluSltu;
                    FnSll:         ctrl.alu_op = AluSll;
                    default:       ctrl = CtrlNop;
                endcase
            end
            OpAddi, OpAddiu: begin
                ctrl.alu_op  = AluAdd;
                ctrl.alu_src = 1'b1;
                ctrl.ext_op  = 1'b1;
                ctrl.reg_wr  = 1'b1;
            end
            OpAndi, OpOri: begin
                ctrl.alu_op  = (opcode == OpAndi) ? AluAnd : AluOr;
                ctrl.alu_src = 1'b1;
                ctrl.reg_wr  = 1'b1;
            end
            OpLw: begin
                ctrl.alu_op     = AluAdd;
                ctrl.alu_src    = 1'b1;
                ctrl.ext_op     = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_wr     = 1'b1;
            end
            OpSw: begin
                ctrl.alu_op  = AluAdd;
                ctrl.alu_src = 1'b1;
                ctrl.ext_op  = 1'b1;
                ctrl.mem_wr  = 1'b1;
            end
            OpBeq, OpBne: begin
                ctrl.alu_op = AluSub;
                ctrl.ext_op = 1'b1;
            end
            default: ctrl = CtrlNop;
        endcase
    end

endmodule

// File: rtl/control.sv
// Registered instruction decoder: controls and raw fields appear one cycle after inst,
// cleared asynchronously by reset.
module control
    import control_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    control_if.slave bus
);

    ctrl_t       ctrl_d;
    ctrl_t       ctrl_q;
    logic [25:0] fields_q;

    control_decode u_decode (
        .opcode (bus.inst[31:26]),
        .funct  (bus.inst[5:0]),
        .ctrl   (ctrl_d)
    );

    // Opcode bits are consumed only by the decode, so just inst[25:0] is kept for fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q   <= CtrlNop;
            fields_q <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            fields_q <= bus.inst[25:0];
        end
    end

    assign bus.alu_op     = ctrl_q.alu_op;
    assign bus.reg_dst    = ctrl_q.reg_dst;
    assign bus.alu_src    = ctrl_q.alu_src;
    assign bus.mem_wr     = ctrl_q.mem_wr;
    assign bus.mem_to_reg = ctrl_q.mem_to_reg;
    assign bus.reg_wr     = ctrl_q.reg_wr;
    assign bus.ext_op     = ctrl_q.ext_op;

    assign bus.rs    = fields_q[25:21];
    assign bus.rt    = fields_q[20:16];
    assign bus.rd    = fields_q[15:11];
    assign bus.shamt = fields_q[10:6];
    assign bus.func  = fields_q[5:0];
    assign bus.imm   = fields_q[15:0];

endmodule

// File: tb/tb_control.sv
// Directed self-checking bench for the registered decoder.
module tb_control;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    control_if bus ();

    control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {alu_op, reg_dst, alu_src, mem_wr, mem_to_reg, reg_wr, ext_op}
    logic [8:0]  got_ctrl;
    logic [25:0] got_fields;
    assign got_ctrl   = {bus.alu_op, bus.reg_dst, bus.alu_src, bus.mem_wr, bus.mem_to_reg,
                         bus.reg_wr, bus.ext_op};
    assign got_fields = {bus.rs, bus.rt, bus.rd, bus.shamt, bus.func};

    task automatic apply(input logic [31:0] i);
        @(negedge clk);
        bus.inst = i;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        bus.inst = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (got_ctrl !== 9'h000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want %b", got_ctrl, 9'h000);
        end
        checks++;
        if (got_fields !== 26'h0 || bus.imm !== 16'h0) begin
            errors++;
            $display("FAIL reset_fields: got %h/%h want 0/0", got_fields, bus.imm);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_addi();
        apply(32'h2005_0001);
        checks++;
        if (got_ctrl !== 9'b000_010011) begin
            errors++;
            $display("FAIL addi_ctrl: got %b want %b", got_ctrl, 9'b000_010011);
        end
        checks++;
        if (got_fields !== {5'd0, 5'd5, 5'd0, 5'd0, 6'h01} || bus.imm !== 16'h0001) begin
            errors++;
            $display("FAIL addi_fields: got %h imm %h want %h imm 0001", got_fields, bus.imm,
                     {5'd0, 5'd5, 5'd0, 5'd0, 6'h01});
        end
    endtask

    task automatic test_add();
        apply(32'h0022_1820);
        checks++;
        if (got_ctrl !== 9'b000_100010) begin
            errors++;
            $display("FAIL add_ctrl: got %b want %b", got_ctrl, 9'b000_100010);
        end
        checks++;
        if (got_fields !== {5'd1, 5'd2, 5'd3, 5'd0, 6'h20}) begin
            errors++;
            $display("FAIL add_fields: got %h want %h", got_fields,
                     {5'd1, 5'd2, 5'd3, 5'd0, 6'h20});
        end
    endtask

    task automatic test_rtype_functs();
        logic [5:0] fn  [9] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h2B, 6'h00};
        logic [2:0] op  [9] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
        logic [5:0] bad [3] = '{6'h01, 6'h26, 6'h3F};
        for (int k = 0; k < 9; k++) begin
            apply({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, fn[k]});
            checks++;
            if (got_ctrl !== {op[k], 6'b100010}) begin
                errors++;
                $display("FAIL rtype_fn_%h: got %b want %b", fn[k], got_ctrl, {op[k], 6'b100010});
            end
        end
        for (int k = 0; k < 3; k++) begin
            apply({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, bad[k]});
            checks++;
            if (got_ctrl !== 9'h000) begin
                errors++;
                $display("FAIL rtype_bad_%h: got %b want %b", bad[k], got_ctrl, 9'h000);
            end
        end
    endtask

    task automatic test_lw_sw();
        apply(32'h8C44_0008);
        checks++;
        if (got_ctrl !== 9'b000_010111) begin
            errors++;
            $display("FAIL lw_ctrl: got %b want %b", got_ctrl, 9'b000_010111);
        end
        apply(32'hAC44_0008);
        checks++;
        if (got_ctrl !== 9'b000_011001 || bus.imm !== 16'h0008) begin
            errors++;
            $display("FAIL sw_ctrl: got %b imm %h want %b imm 0008", got_ctrl, bus.imm,
                     9'b000_011001);
        end
    endtask

    task automatic test_immediates();
        logic [31:0] ins [5] = '{32'h3445_FFFF, 32'h3045_00F0, 32'h2445_8000,
                                 32'h1043_0004, 32'h1443_FFFC};
        logic [8:0]  exp [5] = '{9'b011_010010, 9'b010_010010, 9'b000_010011,
                                 9'b001_000001, 9'b001_000001};
        for (int k = 0; k < 5; k++) begin
            apply(ins[k]);
            checks++;
            if (got_ctrl !== exp[k]) begin
                errors++;
                $display("FAIL imm_%h: got %b want %b", ins[k], got_ctrl, exp[k]);
            end
        end
        apply(32'h3445_FFFF);
        checks++;
        if (bus.imm !== 16'hFFFF || bus.rs !== 5'd2 || bus.rt !== 5'd5) begin
            errors++;
            $display("FAIL ori_fields: got imm %h rs %0d rt %0d want FFFF 2 5",
                     bus.imm, bus.rs, bus.rt);
        end
    endtask

    task automatic test_unsupported();
        apply(32'hFC00_0000);
        checks++;
        if (got_ctrl !== 9'h000) begin
            errors++;
            $display("FAIL unsup_ctrl: got %b want %b", got_ctrl, 9'h000);
        end
        apply(32'hFC00_FFFF);
        checks++;
        if (got_ctrl !== 9'h000 || got_fields !== {5'd0, 5'd0, 5'd31, 5'd31, 6'h3F} ||
            bus.imm !== 16'hFFFF) begin
            errors++;
            $display("FAIL unsup_fields: got %b %h imm %h want 0 %h imm FFFF", got_ctrl,
                     got_fields, bus.imm, {5'd0, 5'd0, 5'd31, 5'd31, 6'h3F});
        end
    endtask

    task automatic test_exclusive();
        for (int k = 0; k < 64; k++) begin
            apply({k[5:0], 20'h12345, 6'h20});
            checks++;
            if (bus.reg_wr === 1'b1 && bus.mem_wr === 1'b1) begin
                errors++;
                $display("FAIL excl_op_%h: got reg_wr %b mem_wr %b want not both 1",
                         k[5:0], bus.reg_wr, bus.mem_wr);
            end
        end
    endtask

    task automatic test_back_to_back();
        apply(32'h2005_0001);
        @(negedge clk);
        bus.inst = 32'h3445_FFFF;
        #1;
        checks++;
        if (got_ctrl !== 9'b000_010011) begin
            errors++;
            $display("FAIL latency_hold: got %b want %b", got_ctrl, 9'b000_010011);
        end
        @(posedge clk);
        #1;
        checks++;
        if (got_ctrl !== 9'b011_010010) begin
            errors++;
            $display("FAIL latency_load: got %b want %b", got_ctrl, 9'b011_010010);
        end
    endtask

    task automatic test_reset_midstream();
        apply(32'h2005_0001);
        checks++;
        if (got_ctrl !== 9'b000_010011) begin
            errors++;
            $display("FAIL mid_preload: got %b want %b", got_ctrl, 9'b000_010011);
        end
        @(negedge clk);
        bus.inst = 32'h3445_FFFF;
        #1 reset = 1'b1;
        #1;
        checks++;
        if (got_ctrl !== 9'h000 || got_fields !== 26'h0 || bus.imm !== 16'h0) begin
            errors++;
            $display("FAIL mid_async_clear: got %b %h %h want all 0", got_ctrl, got_fields,
                     bus.imm);
        end
        @(posedge clk);
        #1;
        checks++;
        if (got_ctrl !== 9'h000 || got_fields !== 26'h0) begin
            errors++;
            $display("FAIL mid_held: got %b %h want all 0", got_ctrl, got_fields);
        end
        @(negedge clk);
        reset    = 1'b0;
        bus.inst = 32'h0022_1820;
        #1;
        checks++;
        if (got_ctrl !== 9'h000) begin
            errors++;
            $display("FAIL mid_no_early: got %b want %b", got_ctrl, 9'h000);
        end
        @(posedge clk);
        #1;
        checks++;
        if (got_ctrl !== 9'b000_100010 || bus.rd !== 5'd3 || bus.func !== 6'h20) begin
            errors++;
            $display("FAIL mid_first_edge: got %b rd %0d func %h want %b rd 3 func 20",
                     got_ctrl, bus.rd, bus.func, 9'b000_100010);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_addi();
        test_add();
        test_rtype_functs();
        test_lw_sw();
        test_immediates();
        test_unsupported();
        test_exclusive();
        test_back_to_back();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control.md
CONTROL -- requirements
Module: control

Interface
REQ-001 Parameters SHALL be none; opcode, funct and ALU-op encodings are fixed localparams from the shared package.
REQ-002 clk  input  1  rising-edge clock for all output registers.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 inst  input  32  instruction word to decode.
REQ-005 alu_op  output  3  ALU operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101 SLTU, 110 SLL, 111 reserved.
REQ-006 reg_dst  output  1  write-register select: 1 = rd, 0 = rt.
REQ-007 alu_src  output  1  ALU B select: 1 = extended immediate, 0 = rt data.
REQ-008 mem_wr  output  1  data-memory write enable.
REQ-009 mem_to_reg  output  1  writeback select: 1 = memory data, 0 = ALU result.
REQ-010 reg_wr  output  1  register-file write enable.
REQ-011 ext_op  output  1  immediate extension: 1 = sign, 0 = zero.
REQ-012 func, shamt, rs, rt, rd, imm  output  6/5/5/5/5/16  raw fields inst[5:0], [10:6], [25:21], [20:16], [15:11], [15:0].

Function
REQ-013 All outputs SHALL be registered: each rising clk edge loads them from the current inst; latency exactly 1 cycle, no handshake.
REQ-014 Field outputs SHALL be raw bit-slices of inst for every opcode, including unsupported ones.
REQ-015 Decode of inst[31:26] SHALL be purely combinational before the output registers.
REQ-016 R-type (opcode 000000): reg_dst=1, alu_src=0, reg_wr=1, mem_wr=0, mem_to_reg=0, ext_op=0.
REQ-017 R-type alu_op by funct: 0x20/0x21 ADD, 0x22/0x23 SUB, 0x24 AND, 0x25 OR, 0x2A SLT, 0x2B SLTU, 0x00 SLL.
REQ-018 R-type with any other funct: reg_wr=0, alu_op=ADD, all other controls 0.
REQ-019 addi 0x08 / addiu 0x09: alu_op ADD, alu_src=1, ext_op=1, reg_wr=1, reg_dst=0, mem_wr=0, mem_to_reg=0.
REQ-020 andi 0x0C / ori 0x0D: alu_op AND/OR, alu_src=1, ext_op=0, reg_wr=1, reg_dst=0.
REQ-021 lw 0x23: ADD, alu_src=1, ext_op=1, mem_to_reg=1, reg_wr=1, reg_dst=0, mem_wr=0.
REQ-022 sw 0x2B: ADD, alu_src=1, ext_op=1, mem_wr=1, reg_wr=0, mem_to_reg=0.
REQ-023 beq 0x04 / bne 0x05: alu_op SUB, alu_src=0, ext_op=1, reg_wr=0, mem_wr=0.
REQ-024 Any other opcode: reg_wr=0, mem_wr=0, all other controls 0, alu_op ADD; no side effects.
REQ-025 reg_wr and mem_wr SHALL never both be 1.

Reset
REQ-026 While reset=1, every output SHALL be 0 immediately, independent of clk.
REQ-027 Reset asserted mid-stream SHALL discard the pending decode; the first edge after deassertion SHALL load that edge's inst.

Structure
REQ-028 Shared package holds opcode, funct and alu_op localparams.
REQ-029 One sub-module, control_decode (combinational opcode/funct to control bits), instantiated inside control ahead of the output registers.

Verification
REQ-030 inst=0x20050001 (addi $5,$0,1), one edge -> alu_op=000, reg_dst=0, alu_src=1, mem_wr=0, mem_to_reg=0, reg_wr=1, ext_op=1, rs=0, rt=5, rd=0, shamt=0, func=0x01, imm=0x0001.
REQ-031 inst=0x00221820 (add $3,$1,$2) -> reg_dst=1, alu_src=0, reg_wr=1, alu_op=000, rs=1, rt=2, rd=3, func=0x20.
REQ-032 inst=0x8C440008 (lw) -> mem_to_reg=1, reg_wr=1, alu_src=1, ext_op=1; then 0xAC440008 (sw) -> mem_wr=1, reg_wr=0, imm=0x0008.
REQ-033 inst=0x3445FFFF (ori) -> alu_op=011, ext_op=0, alu_src=1, reg_wr=1, imm=0xFFFF.
REQ-034 inst=0xFC000000 (unsupported) -> reg_wr=0, mem_wr=0, alu_op=000.
REQ-035 Assert reset between edges after an addi load -> all outputs 0 at once; deassert, next edge -> outputs match the inst applied at that edge.
